// File: rtl/delay_line_var_pkg.sv
// delay_line_pkg: shared helpers for the variable delay line.
//   delay_w(max_delay) - width of a select able to encode 0..max_delay.
// The {valid, data} stage struct depends on WIDTH. A package cannot hold a
// parametrised typedef, so each user declares the template locally:
//   typedef struct packed { logic valid; logic [WIDTH-1:0] data; } stage_t;
package delay_line_pkg;

    function automatic int unsigned delay_w(input int unsigned max_delay);
        return $clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/delay_line_var_if.sv
// delay_line_if: stream and delay-select bundle for delay_line_var.
//   data_i/valid_i  input word and qualifier (driven by master)
//   delay_i         selected delay in cycles (driven by master)
//   data_o/valid_o  delayed word and qualifier (driven by slave)
interface delay_line_if
    import delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_DELAY = 15,
    parameter int unsigned DW        = delay_w(MAX_DELAY)
) ();

    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic [DW-1:0]    delay_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;

    modport master (
        output data_i,
        output valid_i,
        output delay_i,
        input  data_o,
        input  valid_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        input  delay_i,
        output data_o,
        output valid_o
    );

endinterface

// File: rtl/delay_line_var_tap_mux.sv
// delay_tap_mux: combinational (MAX_DELAY+1)-to-1 tap selector.
//   live_i   {valid, data} presented this cycle (tap 0)
//   stages_i shift-register stages; stage k is tap k+1
//   sel_i    requested delay; values above MAX_DELAY clamp to MAX_DELAY
//   tap_o    selected {valid, data}
module delay_tap_mux
    import delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_DELAY = 15,
    parameter int unsigned DW        = delay_w(MAX_DELAY)
) (
    input  logic [WIDTH:0]                live_i,
    input  logic [MAX_DELAY-1:0][WIDTH:0] stages_i,
    input  logic [DW-1:0]                 sel_i,
    output logic [WIDTH:0]                tap_o
);

    localparam logic [DW-1:0] MaxSel = DW'(MAX_DELAY);

    logic [DW-1:0] sel;

    // Compare against every legal tap rather than indexing with sel, so the
    // select width never has to match the stage-array index width.
    always_comb begin
        sel   = (sel_i > MaxSel) ? MaxSel : sel_i;
        tap_o = live_i;
        for (int k = 1; k <= int'(MAX_DELAY); k++) begin
            if (sel == DW'(k)) begin
                tap_o = stages_i[k-1];
            end
        end
    end

endmodule

// File: rtl/delay_line_var.sv
// delay_line_var: delays a WIDTH-bit word plus valid bit by a run-time
// selectable 0..MAX_DELAY cycles (delay_i clamps at MAX_DELAY).
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset, clears all stages
//   bus_io  delay_line_if slave: data_i/valid_i/delay_i in, data_o/valid_o out
// Optional build macro DELAY_LINE_VAR_OUT_REG_EN: registers {valid_o, data_o}
// after the tap mux, adding one cycle of latency (delay 0 becomes 1 cycle).
module delay_line_var
    import delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_DELAY = 15,
    parameter int unsigned DW        = delay_w(MAX_DELAY)
) (
    input logic         clk_i,
    input logic         rst_i,
    delay_line_if.slave bus_io
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t                 live;
    stage_t [MAX_DELAY-1:0] stages_q;
    stage_t [MAX_DELAY-1:0] stages_d;
    stage_t                 tap;

    assign live.valid = bus_io.valid_i;
    assign live.data  = bus_io.data_i;

    always_comb begin
        stages_d    = stages_q;
        stages_d[0] = live;
        for (int k = 1; k < int'(MAX_DELAY); k++) begin
            stages_d[k] = stages_q[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stages_q <= '0;
        end else begin
            stages_q <= stages_d;
        end
    end

    // The tap follows delay_i on the same cycle, even during reset.
    delay_tap_mux #(
        .WIDTH     (WIDTH),
        .MAX_DELAY (MAX_DELAY),
        .DW        (DW)
    ) u_tap_mux (
        .live_i   (live),
        .stages_i (stages_q),
        .sel_i    (bus_io.delay_i),
        .tap_o    (tap)
    );

`ifdef DELAY_LINE_VAR_OUT_REG_EN
    stage_t out_q;
    stage_t out_d;

    assign out_d = tap;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus_io.valid_o = out_q.valid;
    assign bus_io.data_o  = out_q.data;
`else
    assign bus_io.valid_o = tap.valid;
    assign bus_io.data_o  = tap.data;
`endif

endmodule

// File: tb/tb_delay_line_var.sv
// Bench for delay_line_var: a main instance (WIDTH=8, MAX_DELAY=15) and a
// clamp instance (MAX_DELAY=10, delay_i held at 15) share the same stimulus.
// Every accepted input is pushed into a history queue; expected outputs are
// taken from that queue at the selected depth.
module tb_delay_line_var;

`ifdef DELAY_LINE_VAR_OUT_REG_EN
    localparam int OutLat = 1;
`else
    localparam int OutLat = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       vin;
    logic [3:0] dly;

    int total = 0;
    int bad   = 0;

    logic [7:0] cnt;
    logic [8:0] hist_q[$];
    logic [8:0] reg_m;
    logic [8:0] reg_c;

    always #5 clk = ~clk;

    delay_line_if #(.WIDTH(8), .MAX_DELAY(15), .DW(4)) bus ();
    delay_line_if #(.WIDTH(8), .MAX_DELAY(10), .DW(4)) bus_c ();

    assign bus.data_i    = din;
    assign bus.valid_i   = vin;
    assign bus.delay_i   = dly;
    assign bus_c.data_i  = din;
    assign bus_c.valid_i = vin;
    assign bus_c.delay_i = 4'd15;

    delay_line_var #(.WIDTH(8), .MAX_DELAY(15), .DW(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    delay_line_var #(.WIDTH(8), .MAX_DELAY(10), .DW(4)) dut_c (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus_c)
    );

    // Tap value the spec requires for a given delay and depth limit.
    function automatic logic [8:0] comb_exp(input int sel, input int maxd);
        int s;
        s = (sel > maxd) ? maxd : sel;
        if (s == 0) return {vin, din};
        return hist_q[s-1];
    endfunction

    function automatic logic [8:0] exp_main();
`ifdef DELAY_LINE_VAR_OUT_REG_EN
        return reg_m;
`else
        return comb_exp(int'(dly), 15);
`endif
    endfunction

    function automatic logic [8:0] exp_clamp();
`ifdef DELAY_LINE_VAR_OUT_REG_EN
        return reg_c;
`else
        return comb_exp(15, 10);
`endif
    endfunction

    // Advance one rising edge and update the history model.
    task automatic tick();
        @(posedge clk);
        reg_m = rst ? 9'h0 : comb_exp(int'(dly), 15);
        reg_c = rst ? 9'h0 : comb_exp(15, 10);
        if (rst) begin
            foreach (hist_q[k]) hist_q[k] = 9'h0;
        end else begin
            hist_q.push_front({vin, din});
            void'(hist_q.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        dly = 4'd5; vin = 1'b1; din = 8'h3C; rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.valid_o, bus.data_o} !== 9'h0) begin
            bad++;
            $display("FAIL reset_main: got %b/%h want 0/00", bus.valid_o, bus.data_o);
        end
        total++;
        if ({bus_c.valid_o, bus_c.data_o} !== 9'h0) begin
            bad++;
            $display("FAIL reset_clamp: got %b/%h want 0/00", bus_c.valid_o, bus_c.data_o);
        end
        tick();
    endtask

    task automatic test_sweep();
        int dl [4] = '{0, 1, 7, 15};
        logic [7:0] want;
        cnt = 8'h10;
        foreach (dl[j]) begin
            dly = 4'(dl[j]);
            for (int i = 0; i < 40; i++) begin
                vin = 1'b1; din = cnt; cnt++;
                @(negedge clk);
                total++;
                if ({bus.valid_o, bus.data_o} !== exp_main()) begin
                    bad++;
                    $display("FAIL sweep_model d=%0d i=%0d: got %b/%h want %h",
                             dl[j], i, bus.valid_o, bus.data_o, exp_main());
                end
                if (i >= 20) begin
                    want = din - 8'(dl[j] + OutLat);
                    total++;
                    if (bus.valid_o !== 1'b1 || bus.data_o !== want) begin
                        bad++;
                        $display("FAIL sweep_latency d=%0d i=%0d: got %b/%h want 1/%h",
                                 dl[j], i, bus.valid_o, bus.data_o, want);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_fill();
        logic exp_v;
        dly = 4'd5; vin = 1'b1; din = 8'h11; rst = 1'b1;
        tick();
        tick();
        rst = 1'b0; din = 8'hA5;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_v = (i >= 5 + OutLat);
            total++;
            if (bus.valid_o !== exp_v) begin
                bad++;
                $display("FAIL fill_valid i=%0d: got %b want %b", i, bus.valid_o, exp_v);
            end
            if (exp_v) begin
                total++;
                if (bus.data_o !== 8'hA5) begin
                    bad++;
                    $display("FAIL fill_data i=%0d: got %h want a5", i, bus.data_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_midstream_reset();
        logic       exp_v;
        logic [7:0] first;
        dly = 4'd15; vin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = cnt; cnt++;
            tick();
        end
        din = cnt; cnt++; rst = 1'b1;
        tick();
        rst = 1'b0;
        first = cnt;
        for (int i = 0; i < 18; i++) begin
            din = cnt; cnt++;
            @(negedge clk);
            exp_v = (i >= 15 + OutLat);
            total++;
            if (bus.valid_o !== exp_v) begin
                bad++;
                $display("FAIL midreset_valid i=%0d: got %b want %b", i, bus.valid_o, exp_v);
            end
            if (i == 15 + OutLat) begin
                total++;
                if (bus.data_o !== first) begin
                    bad++;
                    $display("FAIL midreset_first: got %h want %h", bus.data_o, first);
                end
            end
            tick();
        end
    endtask

    task automatic test_delay_change();
        logic [7:0] want;
        vin = 1'b1; dly = 4'd3;
        for (int i = 0; i < 20; i++) begin
            din = cnt; cnt++;
            @(negedge clk);
            total++;
            if ({bus.valid_o, bus.data_o} !== exp_main()) begin
                bad++;
                $display("FAIL change_pre i=%0d: got %b/%h want %h",
                         i, bus.valid_o, bus.data_o, exp_main());
            end
            tick();
        end
        dly = 4'd10;
        for (int i = 0; i < 15; i++) begin
            din = cnt; cnt++;
            @(negedge clk);
            total++;
            if ({bus.valid_o, bus.data_o} !== exp_main()) begin
                bad++;
                $display("FAIL change_model i=%0d: got %b/%h want %h",
                         i, bus.valid_o, bus.data_o, exp_main());
            end
            if (i >= OutLat) begin
                want = din - 8'(10 + OutLat);
                total++;
                if (bus.data_o !== want) begin
                    bad++;
                    $display("FAIL change_tap i=%0d: got %h want %h", i, bus.data_o, want);
                end
            end
            tick();
        end
    endtask

    task automatic test_clamp();
        logic [7:0] want;
        vin = 1'b1; dly = 4'd10;
        for (int i = 0; i < 30; i++) begin
            din = cnt; cnt++;
            @(negedge clk);
            total++;
            if ({bus_c.valid_o, bus_c.data_o} !== exp_clamp()) begin
                bad++;
                $display("FAIL clamp_model i=%0d: got %b/%h want %h",
                         i, bus_c.valid_o, bus_c.data_o, exp_clamp());
            end
            want = din - 8'(10 + OutLat);
            total++;
            if (bus_c.valid_o !== 1'b1 || bus_c.data_o !== want) begin
                bad++;
                $display("FAIL clamp_latency i=%0d: got %b/%h want 1/%h",
                         i, bus_c.valid_o, bus_c.data_o, want);
            end
            total++;
            if (bus_c.data_o !== bus.data_o && bus.data_o === want) begin
                bad++;
                $display("FAIL clamp_vs_ten i=%0d: got %h want %h", i, bus_c.data_o, want);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 15; k++) hist_q.push_back(9'h0);
        reg_m = 9'h0; reg_c = 9'h0;
        cnt = 8'h00; rst = 1'b1; vin = 1'b0; din = 8'h00; dly = 4'd0;
        #1;
        test_reset();
        test_sweep();
        test_fill();
        test_midstream_reset();
        test_delay_change();
        test_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
